// File: rtl/term_src_fifo_pkg.sv
// Shared packet-field widths, header layout and occupancy states for the mesh
// terminal source path.
package term_src_fifo_pkg;

    localparam int NXT_JMP_W = 8;
    localparam int ROW_W     = 4;
    localparam int COL_W     = 4;
    localparam int MODE_W    = 1;
    localparam int HDR_W     = NXT_JMP_W + ROW_W + COL_W + MODE_W;

    // Header sits above the payload, MSB first; routers rewrite nxt_jump in flight.
    typedef struct packed {
        logic [NXT_JMP_W-1:0] nxt_jump;
        logic [ROW_W-1:0]     row;
        logic [COL_W-1:0]     col;
        logic [MODE_W-1:0]    mode;
    } pkt_hdr_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

    function automatic pkt_hdr_t make_hdr(input logic [ROW_W-1:0]  row,
                                          input logic [COL_W-1:0]  col,
                                          input logic [MODE_W-1:0] mode);
        pkt_hdr_t h;
        h.nxt_jump = '0;
        h.row      = row;
        h.col      = col;
        h.mode     = mode;
        return h;
    endfunction

endpackage

// File: rtl/term_src_fifo_if.sv
// Producer-side descriptor handshake plus mesh-terminal show-ahead port.
interface term_src_fifo_if
    import term_src_fifo_pkg::*;
#(
    parameter int pckg_sz = 32
);
    logic                      in_vld;
    logic                      in_rdy;
    logic [ROW_W-1:0]          in_row;
    logic [COL_W-1:0]          in_col;
    logic [MODE_W-1:0]         in_mode;
    logic [pckg_sz-HDR_W-1:0]  in_payload;
    logic                      pndng;
    logic [pckg_sz-1:0]        data_out;
    logic                      popin;

    modport master (
        output in_vld, in_row, in_col, in_mode, in_payload, popin,
        input  in_rdy, pndng, data_out
    );

    modport slave (
        input  in_vld, in_row, in_col, in_mode, in_payload, popin,
        output in_rdy, pndng, data_out
    );
endinterface

// File: rtl/term_fifo_core.sv
// Circular packet storage with wrapping read/write pointers; the caller
// qualifies push/pop so this block never sees an overflow or underflow.
module term_fifo_core #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
endmodule

// File: rtl/term_src_fifo.sv
// Mesh terminal source FIFO: assembles packets from descriptors, queues them and
// presents the head to the terminal with pop accounting and an empty-pop flag.
module term_src_fifo
    import term_src_fifo_pkg::*;
#(
    parameter int pckg_sz    = 32,
    parameter int fifo_depth = 8,
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    term_src_fifo_if.slave                   bus,
    output logic [$clog2(fifo_depth+1)-1:0]  count,
    output logic [15:0]                      sent_cnt,
    output logic                             err_pop_empty
);
    localparam int CNT_W = $clog2(fifo_depth + 1);

    if (pckg_sz < 24 || fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0 ||
        ROWS < 1 || ROWS > (1 << ROW_W) || COLUMS < 1 || COLUMS > (1 << COL_W)) begin : g_bad_cfg
        $error("term_src_fifo: unsupported parameter set");
    end

    occ_state_t         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pndng_q;
    logic [15:0]        sent_q;
    logic               err_q;
    logic               push, pop;
    logic [pckg_sz-1:0] wdata, rdata;

    assign bus.in_rdy = (state_q != OCC_FULL);
    assign push       = bus.in_vld && bus.in_rdy;
    assign pop        = bus.popin && pndng_q;
    assign wdata      = {make_hdr(bus.in_row, bus.in_col, bus.in_mode), bus.in_payload};

    always_comb begin
        count_d = count_q;
        state_d = state_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
        if (count_d == '0)                      state_d = OCC_EMPTY;
        else if (count_d == CNT_W'(fifo_depth)) state_d = OCC_FULL;
        else                                    state_d = OCC_PARTIAL;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= OCC_EMPTY;
            count_q <= '0;
            pndng_q <= 1'b0;
            sent_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pndng_q <= (state_d != OCC_EMPTY);
            if (pop)                        sent_q <= sent_q + 16'd1;
            if (bus.popin && !pndng_q)      err_q  <= 1'b1;
        end
    end

    term_fifo_core #(
        .DATA_W (pckg_sz),
        .DEPTH  (fifo_depth)
    ) u_core (
        .clk     (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    // Storage is never cleared, so gate the head to keep it defined while empty.
    assign bus.data_out  = pndng_q ? rdata : '0;
    assign bus.pndng     = pndng_q;
    assign count         = count_q;
    assign sent_cnt      = sent_q;
    assign err_pop_empty = err_q;
endmodule

// File: tb/tb_term_src_fifo.sv
// Scenario bench for term_src_fifo with a packet scoreboard queue.
module tb_term_src_fifo;
    localparam int PSZ   = 32;
    localparam int DEPTH = 8;
    localparam int PW    = PSZ - 17;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  count;
    logic [15:0] sent_cnt;
    logic        err_pop_empty;

    int errors = 0;
    int checks = 0;
    logic [PSZ-1:0] sb[$];
    int          exp_cnt = 0;
    logic [15:0] exp_sent = 16'd0;
    logic [PSZ-1:0] exp_pkt;

    term_src_fifo_if #(.pckg_sz(PSZ)) bus ();

    term_src_fifo #(
        .pckg_sz    (PSZ),
        .fifo_depth (DEPTH),
        .ROWS       (4),
        .COLUMS     (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .count         (count),
        .sent_cnt      (sent_cnt),
        .err_pop_empty (err_pop_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one descriptor for a cycle; the model decides acceptance from its own occupancy.
    task automatic push_pkt(input logic [3:0] r, input logic [3:0] c, input logic m,
                            input logic [PW-1:0] p);
        bus.in_vld     = 1'b1;
        bus.in_row     = r;
        bus.in_col     = c;
        bus.in_mode    = m;
        bus.in_payload = p;
        if (exp_cnt != DEPTH) begin
            sb.push_back({8'h00, r, c, m, p});
            exp_cnt++;
        end
        step();
        bus.in_vld = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_vld = 1'b1;
        bus.popin  = 1'b1;
        step();
        step();
        bus.in_vld = 1'b0;
        bus.popin  = 1'b0;
        checks++; if (bus.pndng !== 1'b0) begin errors++; $display("FAIL reset_pndng got=%b want=0", bus.pndng); end
        checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got=%b want=1", bus.in_rdy); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
        checks++; if (sent_cnt !== 16'd0) begin errors++; $display("FAIL reset_sent got=%0d want=0", sent_cnt); end
        checks++; if (bus.data_out !== 32'h0) begin errors++; $display("FAIL reset_data got=%h want=0", bus.data_out); end
        checks++; if (err_pop_empty !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err_pop_empty); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        push_pkt(4'd4, 4'd5, 1'b1, 15'h2A55);
        checks++; if (bus.pndng !== 1'b1) begin errors++; $display("FAIL single_pndng got=%b want=1", bus.pndng); end
        checks++; if (bus.data_out !== 32'h0045AA55) begin errors++; $display("FAIL single_data got=%h want=0045aa55", bus.data_out); end
        exp_pkt = sb.pop_front();
        checks++; if (bus.data_out !== exp_pkt) begin errors++; $display("FAIL single_sb got=%h want=%h", bus.data_out, exp_pkt); end
        bus.popin = 1'b1;
        step();
        bus.popin = 1'b0;
        exp_cnt--;
        exp_sent++;
        checks++; if (bus.pndng !== 1'b0) begin errors++; $display("FAIL single_pop_pndng got=%b want=0", bus.pndng); end
        checks++; if (sent_cnt !== exp_sent) begin errors++; $display("FAIL single_sent got=%0d want=%0d", sent_cnt, exp_sent); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            push_pkt(4'd1, 4'd2, 1'b0, PW'(i));
            checks++; if (count !== 4'(exp_cnt)) begin errors++; $display("FAIL full_fill_count got=%0d want=%0d", count, exp_cnt); end
        end
        checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL full_in_rdy got=%b want=0", bus.in_rdy); end
        push_pkt(4'd1, 4'd2, 1'b0, PW'(8));
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_ninth_count got=%0d want=8", count); end
        for (int i = 0; i < DEPTH; i++) begin
            exp_pkt = sb.pop_front();
            checks++; if (bus.data_out !== exp_pkt) begin errors++; $display("FAIL full_order[%0d] got=%h want=%h", i, bus.data_out, exp_pkt); end
            bus.popin = 1'b1;
            step();
            bus.popin = 1'b0;
            exp_cnt--;
            exp_sent++;
        end
        checks++; if (count !== 4'd0 || bus.pndng !== 1'b0) begin errors++; $display("FAIL full_drained count=%0d pndng=%b want 0/0", count, bus.pndng); end
        checks++; if (sent_cnt !== exp_sent) begin errors++; $display("FAIL full_sent got=%0d want=%0d", sent_cnt, exp_sent); end
    endtask

    task automatic test_concurrency();
        for (int i = 0; i < 3; i++) push_pkt(4'd2, 4'd3, 1'b1, PW'(16'h100 + i));
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL conc_count3 got=%0d want=3", count); end
        // push and pop together at partial occupancy
        exp_pkt = sb.pop_front();
        checks++; if (bus.data_out !== exp_pkt) begin errors++; $display("FAIL conc_head got=%h want=%h", bus.data_out, exp_pkt); end
        exp_cnt--;
        exp_sent++;
        bus.popin = 1'b1;
        push_pkt(4'd2, 4'd3, 1'b1, PW'(16'h103));
        bus.popin = 1'b0;
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL conc_count_hold got=%0d want=3", count); end
        for (int i = 0; i < 5; i++) push_pkt(4'd2, 4'd3, 1'b0, PW'(16'h200 + i));
        checks++; if (count !== 4'd8 || bus.in_rdy !== 1'b0) begin errors++; $display("FAIL conc_full count=%0d in_rdy=%b want 8/0", count, bus.in_rdy); end
        // push and pop together while full: only the pop takes effect
        exp_pkt = sb.pop_front();
        checks++; if (bus.data_out !== exp_pkt) begin errors++; $display("FAIL conc_full_head got=%h want=%h", bus.data_out, exp_pkt); end
        bus.popin = 1'b1;
        push_pkt(4'd9, 4'd9, 1'b1, PW'(16'h7AAA));
        bus.popin = 1'b0;
        exp_cnt--;
        exp_sent++;
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL conc_full_count got=%0d want=7", count); end
        while (sb.size() > 0) begin
            exp_pkt = sb.pop_front();
            checks++; if (bus.data_out !== exp_pkt) begin errors++; $display("FAIL conc_order got=%h want=%h", bus.data_out, exp_pkt); end
            bus.popin = 1'b1;
            step();
            bus.popin = 1'b0;
            exp_cnt--;
            exp_sent++;
        end
        checks++; if (count !== 4'd0 || sent_cnt !== exp_sent) begin errors++; $display("FAIL conc_end count=%0d sent=%0d want 0/%0d", count, sent_cnt, exp_sent); end
    endtask

    task automatic test_error();
        checks++; if (err_pop_empty !== 1'b0) begin errors++; $display("FAIL err_pre got=%b want=0", err_pop_empty); end
        bus.popin = 1'b1;
        step();
        bus.popin = 1'b0;
        checks++; if (err_pop_empty !== 1'b1) begin errors++; $display("FAIL err_set got=%b want=1", err_pop_empty); end
        checks++; if (count !== 4'd0 || sent_cnt !== exp_sent) begin errors++; $display("FAIL err_state count=%0d sent=%0d want 0/%0d", count, sent_cnt, exp_sent); end
        push_pkt(4'd0, 4'd1, 1'b0, PW'(16'h0011));
        step();
        checks++; if (err_pop_empty !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", err_pop_empty); end
        sb.delete();
        exp_cnt = 0;
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_sent = 16'd0;
        for (int i = 0; i < 5; i++) push_pkt(4'd3, 4'd3, 1'b0, PW'(16'h300 + i));
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL mid_count5 got=%0d want=5", count); end
        bus.popin = 1'b1;
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus.popin = 1'b0;
        sb.delete();
        exp_cnt = 0;
        checks++; if (count !== 4'd0 || bus.pndng !== 1'b0) begin errors++; $display("FAIL mid_reset count=%0d pndng=%b want 0/0", count, bus.pndng); end
        checks++; if (err_pop_empty !== 1'b0 || sent_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_flags err=%b sent=%0d want 0/0", err_pop_empty, sent_cnt); end
        push_pkt(4'd7, 4'd6, 1'b1, PW'(16'h7777));
        exp_pkt = sb.pop_front();
        checks++; if (bus.data_out !== exp_pkt) begin errors++; $display("FAIL mid_first got=%h want=%h", bus.data_out, exp_pkt); end
        bus.popin = 1'b1;
        step();
        bus.popin = 1'b0;
        exp_cnt--;
        exp_sent++;
        checks++; if (sent_cnt !== exp_sent || bus.pndng !== 1'b0) begin errors++; $display("FAIL mid_pop sent=%0d pndng=%b want %0d/0", sent_cnt, bus.pndng, exp_sent); end
    endtask

    initial begin
        bus.in_vld     = 1'b0;
        bus.in_row     = '0;
        bus.in_col     = '0;
        bus.in_mode    = '0;
        bus.in_payload = '0;
        bus.popin      = 1'b0;
        test_reset();
        test_single();
        test_full();
        test_concurrency();
        test_error();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/term_src_fifo.md
TERM_SRC_FIFO -- requirements
Module: term_src_fifo

Interface
REQ-001 Parameter pckg_sz, default 32: packet width in bits; SHALL be >= 24.
REQ-002 Parameter fifo_depth, default 8: packet entries; SHALL be a power of two >= 2.
REQ-003 Parameter ROWS, default 4: mesh rows; the block carries it only for consistency with the mesh.
REQ-004 Parameter COLUMS, default 4: mesh columns; the block carries it only for consistency with the mesh.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 in_vld  in  1  producer offers a packet descriptor.
REQ-008 in_rdy  out  1  block accepts the descriptor this cycle.
REQ-009 in_row  in  4  destination row.
REQ-010 in_col  in  4  destination column.
REQ-011 in_mode  in  1  routing mode bit.
REQ-012 in_payload  in  pckg_sz-17  payload.
REQ-013 pndng  out  1  head packet available to the mesh terminal.
REQ-014 data_out  out  pckg_sz  head packet (show-ahead), wired to the mesh terminal data input.
REQ-015 popin  in  1  mesh terminal consumed the head packet this cycle.
REQ-016 count  out  $clog2(fifo_depth+1)  current occupancy.
REQ-017 sent_cnt  out  16  packets popped by the mesh since reset.
REQ-018 err_pop_empty  out  1  sticky flag: popin arrived while empty.

Function
REQ-019 Packet SHALL be {8'h00 nxt_jump, in_row, in_col, in_mode, in_payload}, MSB first; nxt_jump is zero at injection.
REQ-020 in_rdy SHALL equal (count != fifo_depth); it is combinational from state only, never from popin.
REQ-021 A push SHALL occur on a rising edge with in_vld && in_rdy; the assembled packet is written at the tail.
REQ-022 pndng SHALL equal (count != 0), registered; latency from push into an empty FIFO to pndng=1 is 1 cycle.
REQ-023 data_out SHALL present the head entry whenever pndng=1; its value while pndng=0 is don't-care but SHALL NOT be X after reset.
REQ-024 popin with pndng=1 SHALL remove the head; the next entry, if any, SHALL appear on data_out the following cycle.
REQ-025 popin with pndng=0 SHALL be ignored for data and count, and SHALL set err_pop_empty, which holds until reset.
REQ-026 A simultaneous push and valid pop SHALL leave count unchanged and preserve FIFO order.
REQ-027 While full, a push SHALL NOT be accepted even if popin is high that cycle.
REQ-028 Read and write pointers SHALL wrap modulo fifo_depth.
REQ-029 Occupancy states SHALL be EMPTY (count=0), PARTIAL, and FULL (count=fifo_depth).
REQ-030 Occupancy transitions SHALL be driven only by the accepted push and valid pop of REQ-021/REQ-024.
REQ-031 sent_cnt SHALL increment by 1 on each valid pop and wrap from 16'hFFFF to 0.

Reset
REQ-032 With reset=0 at a rising edge, the next cycle SHALL show count=0, pndng=0, in_rdy=1, sent_cnt=0, err_pop_empty=0 and data_out=0.
REQ-033 Reset SHALL take priority over a simultaneous push or pop.
REQ-034 Reset mid-operation SHALL discard all stored packets.
REQ-035 Storage contents need not be cleared by reset.

Structure
REQ-036 Field widths SHALL be shared package constants: NXT_JMP_W=8, ROW_W=4, COL_W=4, MODE_W=1.
REQ-037 The packet-field layout SHALL be a shared package typedef, reused by the mesh routers and other terminal agents.
REQ-038 Storage and pointers SHALL be one sub-module, term_fifo_core.
REQ-039 Packet assembly, counters and the error flag SHALL reside in term_src_fifo.

Verification
REQ-040 Reset: hold reset=0 for 2 cycles -> pndng=0, in_rdy=1, count=0, sent_cnt=0, data_out=0.
REQ-041 Single packet: push row=4, col=5, mode=1, payload=15'h2A55 -> next cycle pndng=1, data_out=32'h0045AA55; one popin cycle -> pndng=0, sent_cnt=1.
REQ-042 Full: push payloads 0..7 -> in_rdy=0 after the 8th; a 9th push is not accepted; 8 pops return 0..7 in order.
REQ-043 Concurrency: at count=3, push and popin in the same cycle -> count stays 3, order preserved; at count=8, push and popin -> count=7, push not accepted.
REQ-044 Error: popin while empty -> err_pop_empty=1 and stays set, count=0, sent_cnt unchanged.
REQ-045 Reset mid-operation: at count=5, assert reset -> next cycle count=0, pndng=0, err_pop_empty=0; a new push after reset is the first packet popped.
